// File: rtl/riscv_pkg.sv
// Shared types for the decode/execute pipeline boundary.
//   operation_e  : decoded operation; NOP (encoding 0) marks a bubble
//   forwarding_e : operand bypass select driven by the hazard unit
//   id_ex_t      : every field held by the ID/EX pipeline register
package riscv_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned PC_W   = 32;
   localparam int unsigned REG_W  = 5;

   typedef enum logic [3:0] {
      NOP    = 4'd0,
      ADD    = 4'd1,
      SUB    = 4'd2,
      AND    = 4'd3,
      OR     = 4'd4,
      XOR    = 4'd5,
      SLL    = 4'd6,
      SRL    = 4'd7,
      SRA    = 4'd8,
      SLT    = 4'd9,
      LOAD   = 4'd10,
      STORE  = 4'd11,
      BRANCH = 4'd12,
      JAL    = 4'd13,
      LUI    = 4'd14,
      AUIPC  = 4'd15
   } operation_e;

   typedef enum logic [1:0] {
      NO_FRWD  = 2'd0,
      EX_FRWD  = 2'd1,
      MEM_FRWD = 2'd2
   } forwarding_e;

   typedef struct packed {
      logic              valid;
      operation_e        op;
      logic [PC_W-1:0]   pc;
      logic [REG_W-1:0]  rs1;
      logic [REG_W-1:0]  rs2;
      logic [REG_W-1:0]  rd;
      logic              rd_wr_ena;
      logic [DATA_W-1:0] opa;
      logic [DATA_W-1:0] opb;
      logic [DATA_W-1:0] imm;
   } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass select: register data, EX result or MEM result.
//   sel        : forwarding_e select; unused encoding falls back to register data
//   reg_data   : register-file read data
//   ex_result  : result of the instruction in EX
//   mem_result : result of the instruction in MEM
//   y          : selected operand (combinational)
module fwd_mux
   import riscv_pkg::*;
#(
   parameter int unsigned W = DATA_W
) (
   input  forwarding_e  sel,
   input  logic [W-1:0] reg_data,
   input  logic [W-1:0] ex_result,
   input  logic [W-1:0] mem_result,
   output logic [W-1:0] y
);

   always_comb begin
      y = reg_data;
      case (sel)
         EX_FRWD:  y = ex_result;
         MEM_FRWD: y = mem_result;
         default:  y = reg_data;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with decode-side operand forwarding and bubble
// insertion on stall/flush. Returns EX rd/write-enable/op to the hazard unit.
// Inputs : clk_i, rstn_i (sync, active-low), decode fields (*D_i),
//          forwardA_i/forwardB_i, ex_result_i, mem_result_i, stall_i, flush_i
// Outputs: registered EX fields (*E_o), opAE_o/opBE_o forwarded operands
// Option : ID_EX_PERF_EN adds saturating stall_cnt_o / flush_cnt_o
module id_ex_stage
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = DATA_W,
   parameter int unsigned PCW  = PC_W
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   input  logic            validD_i,
   input  operation_e      opD_i,
   input  logic [PCW-1:0]  pcD_i,
   input  logic [4:0]      rs1D_i,
   input  logic [4:0]      rs2D_i,
   input  logic [4:0]      rdD_i,
   input  logic            rd_wr_enaD_i,
   input  logic [XLEN-1:0] rs1_dataD_i,
   input  logic [XLEN-1:0] rs2_dataD_i,
   input  logic [XLEN-1:0] immD_i,
   input  forwarding_e     forwardA_i,
   input  forwarding_e     forwardB_i,
   input  logic [XLEN-1:0] ex_result_i,
   input  logic [XLEN-1:0] mem_result_i,
   input  logic            stall_i,
   input  logic            flush_i,
   output logic            validE_o,
   output operation_e      opE_o,
   output logic [PCW-1:0]  pcE_o,
   output logic [4:0]      rs1E_o,
   output logic [4:0]      rs2E_o,
   output logic [4:0]      rdE_o,
   output logic            rdE_wr_ena_o,
   output logic [XLEN-1:0] opAE_o,
   output logic [XLEN-1:0] opBE_o,
`ifdef ID_EX_PERF_EN
   output logic [31:0]     stall_cnt_o,
   output logic [31:0]     flush_cnt_o,
`endif
   output logic [XLEN-1:0] immE_o
);

   logic [XLEN-1:0] opa_fwd;
   logic [XLEN-1:0] opb_fwd;
   logic            bubble;
   id_ex_t          d;
   id_ex_t          q;

   fwd_mux #(.W(XLEN)) u_fwd_a (
      .sel        (forwardA_i),
      .reg_data   (rs1_dataD_i),
      .ex_result  (ex_result_i),
      .mem_result (mem_result_i),
      .y          (opa_fwd)
   );

   fwd_mux #(.W(XLEN)) u_fwd_b (
      .sel        (forwardB_i),
      .reg_data   (rs2_dataD_i),
      .ex_result  (ex_result_i),
      .mem_result (mem_result_i),
      .y          (opb_fwd)
   );

   // Flush and stall both collapse to the same bubble; flush needs no replay.
   assign bubble = flush_i | stall_i | ~validD_i;

   always_comb begin
      d           = '0;
      d.valid     = validD_i;
      d.op        = opD_i;
      d.pc        = pcD_i;
      d.rs1       = rs1D_i;
      d.rs2       = rs2D_i;
      d.rd        = rdD_i;
      d.rd_wr_ena = rd_wr_enaD_i;
      d.opa       = opa_fwd;
      d.opb       = opb_fwd;
      d.imm       = immD_i;
   end

   // Bubbles clear control/index fields but hold data fields.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         q <= '0;
      end else if (bubble) begin
         q.valid     <= 1'b0;
         q.op        <= NOP;
         q.rs1       <= '0;
         q.rs2       <= '0;
         q.rd        <= '0;
         q.rd_wr_ena <= 1'b0;
      end else begin
         q <= d;
      end
   end

   assign validE_o     = q.valid;
   assign opE_o        = q.op;
   assign pcE_o        = q.pc;
   assign rs1E_o       = q.rs1;
   assign rs2E_o       = q.rs2;
   assign rdE_o        = q.rd;
   assign rdE_wr_ena_o = q.rd_wr_ena;
   assign opAE_o       = q.opa;
   assign opBE_o       = q.opb;
   assign immE_o       = q.imm;

`ifdef ID_EX_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   // Saturating event counters; a combined stall+flush counts as a flush only.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_i && !flush_i && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if (flush_i && (flush_cnt_q != 32'hFFFF_FFFF))
            flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
